// File: rtl/cycle_limit_counter.sv
// cycle_limit_counter: run-length timer that counts enabled cycles up or down
// against a latched limit, flags terminal steps, optionally reloads, and can
// end simulation when the run completes.
module cycle_limit_counter #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          FINISH_EN = 1'b1,
    parameter int unsigned WRAPS_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               en_i,
    input  logic [1:0]         mode_i,
    input  logic [WIDTH-1:0]   limit_i,
    output logic [WIDTH-1:0]   count_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               tc_o,
    output logic [WRAPS_W-1:0] wraps_o
);

    localparam int unsigned MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_FREE      = 2'd0;
    localparam logic [MODE_W-1:0] MODE_UP_STOP   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_DOWN_STOP = 2'd2;
    localparam logic [MODE_W-1:0] MODE_UP_WRAP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [WIDTH-1:0]    count_n;
    logic [WIDTH-1:0]    limit_q, limit_n;
    logic [MODE_W-1:0]   mode_q, mode_n;
    logic [WRAPS_W-1:0]  wraps_n;
    logic                tc_n;
    logic                busy_n;
    logic                done_n;
    logic [WIDTH-1:0]    term_c;
    logic                at_term_c;

    // Terminal value for the latched mode
    always_comb begin
        term_c = limit_q;
        case (mode_q)
            MODE_FREE:      term_c = '1;
            MODE_DOWN_STOP: term_c = '0;
            default:        term_c = limit_q;
        endcase
        at_term_c = (count_o == term_c);
    end

    // Next-state and next-output logic; abort beats start beats step
    always_comb begin
        state_n = state_q;
        count_n = count_o;
        limit_n = limit_q;
        mode_n  = mode_q;
        wraps_n = wraps_o;
        tc_n    = 1'b0;

        if (abort_i && (state_q != IDLE)) begin
            state_n = IDLE;
        end else if (start_i) begin
            state_n = RUN;
            mode_n  = mode_i;
            limit_n = limit_i;
            wraps_n = '0;
            count_n = (mode_i == MODE_DOWN_STOP) ? limit_i : '0;
        end else if ((state_q == RUN) && en_i) begin
            if (at_term_c) begin
                tc_n = 1'b1;
                case (mode_q)
                    MODE_UP_STOP, MODE_DOWN_STOP: state_n = DONE;
                    default: begin
                        count_n = '0;
                        if (wraps_o != '1) begin
                            wraps_n = wraps_o + WRAPS_W'(1);
                        end
                    end
                endcase
            end else if (mode_q == MODE_DOWN_STOP) begin
                count_n = count_o - WIDTH'(1);
            end else begin
                count_n = count_o + WIDTH'(1);
            end
        end

        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_o <= '0;
            limit_q <= '0;
            mode_q  <= MODE_UP_STOP;
            wraps_o <= '0;
            tc_o    <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_n;
            count_o <= count_n;
            limit_q <= limit_n;
            mode_q  <= mode_n;
            wraps_o <= wraps_n;
            tc_o    <= tc_n;
            busy_o  <= busy_n;
            done_o  <= done_n;
        end
    end

`ifndef SYNTHESIS
    // End the simulation on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (FINISH_EN && !reset && (state_q != DONE) && (state_n == DONE)) begin
            $write("*-* All Finished *-*\n");
            $finish;
        end
    end
`endif

endmodule
